// File: rtl/dma_pkg.sv
// Shared types and constants for the DMA copy engine.
// Used by the burst scheduler and its beat calculator.
package dma_pkg;

  localparam int AXI_ADDR_BITS = 32;
  localparam int AXI_DATA_BITS = 32;
  localparam int BOUNDARY_DEF  = 4096;
  localparam int AXLEN_BITS    = 8;

  typedef enum logic [2:0] {
    IDLE,
    CALC,
    RD_CMD,
    RD_WAIT,
    WR_CMD,
    WR_WAIT,
    DONE
  } state_t;

endpackage

// File: rtl/dma_burst_calc.sv
// Beat count for the next burst: min of remaining words,
// max burst size and the room left before each boundary.
module dma_burst_calc
  import dma_pkg::*;
#(
  parameter int MAX_BEATS = 16,
  parameter int BOUNDARY  = BOUNDARY_DEF
) (
  input  logic [AXI_ADDR_BITS-1:0] remain,
  input  logic [AXI_ADDR_BITS-1:0] src,
  input  logic [AXI_ADDR_BITS-1:0] dst,
  output logic [AXLEN_BITS:0]      beats
);

  localparam logic [31:0] BND  = 32'(BOUNDARY);
  localparam logic [31:0] MASK = BND - 32'd1;
  localparam logic [31:0] MAXB = 32'(MAX_BEATS);

  logic [31:0] src_room;
  logic [31:0] dst_room;
  logic [31:0] m;

  function automatic logic [31:0] min2(
    input logic [31:0] a,
    input logic [31:0] b
  );
    return (a < b) ? a : b;
  endfunction

  always_comb begin
    src_room = (BND - (src & MASK)) >> 2;
    dst_room = (BND - (dst & MASK)) >> 2;
    m = min2(min2(remain, MAXB),
             min2(src_room, dst_room));
    beats = (AXLEN_BITS+1)'(m);
  end

endmodule

// File: rtl/dma_burst_sched.sv
// DMA job sequencer: splits one copy job into alternating
// read/write bursts and raises a sticky irq at the end.
module dma_burst_sched
  import dma_pkg::*;
#(
  parameter int MAX_BEATS = 16,
  parameter int BOUNDARY  = BOUNDARY_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] src,
  input  logic [31:0] dst,
  input  logic [31:0] len,
  output logic        rd_cmd_valid,
  input  logic        rd_cmd_ready,
  output logic [31:0] rd_cmd_addr,
  output logic [7:0]  rd_cmd_len,
  input  logic        rd_done,
  input  logic        rd_err,
  output logic        wr_cmd_valid,
  input  logic        wr_cmd_ready,
  output logic [31:0] wr_cmd_addr,
  output logic [7:0]  wr_cmd_len,
  input  logic        wr_done,
  input  logic        wr_err,
  output logic        busy,
  output logic        err,
  output logic        irq,
  input  logic        irq_clr
);

  state_t      state;
  state_t      state_nx;
  logic [31:0] cur_src;
  logic [31:0] cur_dst;
  logic [31:0] remain;
  logic [8:0]  beats_q;
  logic [8:0]  beats_c;
  logic [7:0]  len_q;
  logic        err_q;

  dma_burst_calc #(
    .MAX_BEATS (MAX_BEATS),
    .BOUNDARY  (BOUNDARY)
  ) u_calc (
    .remain (remain),
    .src    (cur_src),
    .dst    (cur_dst),
    .beats  (beats_c)
  );

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:
        if (start)
          state_nx = (len == '0) ? DONE : CALC;
      CALC:
        state_nx = RD_CMD;
      RD_CMD:
        if (rd_cmd_ready) state_nx = RD_WAIT;
      RD_WAIT:
        if (rd_done)
          state_nx = rd_err ? DONE : WR_CMD;
      WR_CMD:
        if (wr_cmd_ready) state_nx = WR_WAIT;
      WR_WAIT:
        if (wr_done) begin
          // last burst when remain equals this burst
          if (wr_err || remain == 32'(beats_q))
            state_nx = DONE;
          else
            state_nx = CALC;
        end
      DONE:
        if (irq_clr) state_nx = IDLE;
      default:
        state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cur_src <= '0;
      cur_dst <= '0;
      remain  <= '0;
      beats_q <= '0;
      len_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      unique case (state)
        IDLE:
          if (start) begin
            cur_src <= {src[31:2], 2'b00};
            cur_dst <= {dst[31:2], 2'b00};
            remain  <= len;
            err_q   <= 1'b0;
          end
        CALC: begin
          beats_q <= beats_c;
          len_q   <= 8'(beats_c - 9'd1);
        end
        RD_WAIT:
          if (rd_done && rd_err) err_q <= 1'b1;
        WR_WAIT:
          if (wr_done) begin
            if (wr_err) begin
              err_q <= 1'b1;
            end else begin
              cur_src <= cur_src + {21'b0, beats_q, 2'b00};
              cur_dst <= cur_dst + {21'b0, beats_q, 2'b00};
              remain  <= remain - 32'(beats_q);
            end
          end
        default: ;
      endcase
    end
  end

  assign rd_cmd_valid = (state == RD_CMD);
  assign rd_cmd_addr  = cur_src;
  assign rd_cmd_len   = len_q;
  assign wr_cmd_valid = (state == WR_CMD);
  assign wr_cmd_addr  = cur_dst;
  assign wr_cmd_len   = len_q;
  assign busy = (state != IDLE) && (state != DONE);
  assign err  = err_q;
  assign irq  = (state == DONE);

endmodule

// File: tb/tb_dma_burst_sched.sv
// Scoreboard bench for dma_burst_sched: expected burst
// commands are queued per job and popped on each handshake.
module tb_dma_burst_sched;

  typedef struct packed {
    logic [31:0] addr;
    logic [7:0]  len;
  } cmd_t;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] src;
  logic [31:0] dst;
  logic [31:0] len;
  logic        rd_cmd_valid;
  logic        rd_cmd_ready;
  logic [31:0] rd_cmd_addr;
  logic [7:0]  rd_cmd_len;
  logic        rd_done;
  logic        rd_err;
  logic        wr_cmd_valid;
  logic        wr_cmd_ready;
  logic [31:0] wr_cmd_addr;
  logic [7:0]  wr_cmd_len;
  logic        wr_done;
  logic        wr_err;
  logic        busy;
  logic        err;
  logic        irq;
  logic        irq_clr;

  cmd_t rq[$];
  cmd_t wq[$];
  int   n_chk;
  int   n_pass;

  dma_burst_sched dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .src          (src),
    .dst          (dst),
    .len          (len),
    .rd_cmd_valid (rd_cmd_valid),
    .rd_cmd_ready (rd_cmd_ready),
    .rd_cmd_addr  (rd_cmd_addr),
    .rd_cmd_len   (rd_cmd_len),
    .rd_done      (rd_done),
    .rd_err       (rd_err),
    .wr_cmd_valid (wr_cmd_valid),
    .wr_cmd_ready (wr_cmd_ready),
    .wr_cmd_addr  (wr_cmd_addr),
    .wr_cmd_len   (wr_cmd_len),
    .wr_done      (wr_done),
    .wr_err       (wr_err),
    .busy         (busy),
    .err          (err),
    .irq          (irq),
    .irq_clr      (irq_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_addr"}, rd_cmd_addr | wr_cmd_addr, 0);
    check({tag, "_ctl"},
          {rd_cmd_valid, wr_cmd_valid, rd_cmd_len,
           wr_cmd_len, busy, err, irq}, 0);
  endtask

  task automatic push_rd(input logic [31:0] a,
                         input logic [7:0] l);
    cmd_t c;
    c.addr = a;
    c.len  = l;
    rq.push_back(c);
  endtask

  task automatic push(input logic [31:0] ra,
                      input logic [31:0] wa,
                      input logic [7:0]  l);
    cmd_t c;
    push_rd(ra, l);
    c.addr = wa;
    c.len  = l;
    wq.push_back(c);
  endtask

  task automatic run_job(
    input logic [31:0] s,
    input logic [31:0] d,
    input logic [31:0] l,
    input int          bp,
    input int          err_at,
    input bit          rst_mid
  );
    int   b;
    int   bpc;
    bit   stop;
    bit   irq_exp;
    cmd_t e;
    b = 0;
    bpc = bp;
    stop = 0;
    irq_exp = 1;
    src = s;
    dst = d;
    len = l;
    start = 1;
    tick();
    start = 0;
    src = '1;
    dst = '1;
    len = '1;
    check("err_clr", err, 0);
    if (l == 0) begin
      check("z_irq", irq, 1);
      check("z_busy", busy, 0);
      repeat (3) begin
        tick();
        check("z_novalid",
              {rd_cmd_valid, wr_cmd_valid}, 0);
      end
      stop = 1;
    end else begin
      check("busy", busy, 1);
    end
    while (!stop) begin
      tick();
      check("rd_valid", rd_cmd_valid, 1);
      if (rq.size() != 0) e = rq.pop_front();
      else e = '1;
      check("rd_addr", rd_cmd_addr, e.addr);
      check("rd_len", rd_cmd_len, e.len);
      repeat (bpc) begin
        tick();
        check("bp_valid", rd_cmd_valid, 1);
        check("bp_addr", rd_cmd_addr, e.addr);
        check("bp_len", rd_cmd_len, e.len);
      end
      bpc = 0;
      rd_cmd_ready = 1;
      tick();
      rd_cmd_ready = 0;
      check("rd_drop", rd_cmd_valid, 0);
      wr_done = 1;
      wr_err = 1;
      tick();
      wr_done = 0;
      wr_err = 0;
      check("rd_wait_hold",
            {rd_cmd_valid, wr_cmd_valid, err}, 0);
      rd_done = 1;
      rd_err = (b == err_at);
      tick();
      rd_done = 0;
      rd_err = 0;
      if (b == err_at) begin
        check("rerr_err", err, 1);
        check("rerr_irq", irq, 1);
        check("rerr_busy", busy, 0);
        repeat (3) begin
          tick();
          check("rerr_nowr", wr_cmd_valid, 0);
        end
        stop = 1;
      end else begin
        check("wr_valid", wr_cmd_valid, 1);
        if (wq.size() != 0) e = wq.pop_front();
        else e = '1;
        check("wr_addr", wr_cmd_addr, e.addr);
        check("wr_len", wr_cmd_len, e.len);
        wr_cmd_ready = 1;
        tick();
        wr_cmd_ready = 0;
        check("wr_drop", wr_cmd_valid, 0);
        if (rst_mid) begin
          rst = 0;
          tick();
          rst = 1;
          check_reset("rst_mid");
          wr_done = 1;
          tick();
          wr_done = 0;
          repeat (4) begin
            tick();
            check("rst_idle",
                  {rd_cmd_valid, wr_cmd_valid,
                   busy, irq}, 0);
          end
          rq.delete();
          wq.delete();
          stop = 1;
          irq_exp = 0;
        end else begin
          tick();
          wr_done = 1;
          tick();
          wr_done = 0;
          if (rq.size() == 0) begin
            check("fin_irq", irq, 1);
            check("fin_busy", busy, 0);
            stop = 1;
          end else begin
            check("calc_busy", busy, 1);
            check("calc_irq", irq, 0);
            check("calc_novalid", rd_cmd_valid, 0);
          end
        end
      end
      b++;
    end
    check("rq_empty", rq.size(), 0);
    check("wq_empty", wq.size(), 0);
    if (irq_exp) begin
      tick();
      check("irq_hold", irq, 1);
      irq_clr = 1;
      start = 1;
      tick();
      irq_clr = 0;
      start = 0;
      check("clr_irq", irq, 0);
      check("clr_busy", busy, 0);
      tick();
      check("start_ign", busy, 0);
    end
  endtask

  initial begin
    n_chk = 0;
    n_pass = 0;
    rst = 0;
    start = 0;
    src = 0;
    dst = 0;
    len = 0;
    rd_cmd_ready = 0;
    rd_done = 0;
    rd_err = 0;
    wr_cmd_ready = 0;
    wr_done = 0;
    wr_err = 0;
    irq_clr = 0;
    repeat (3) tick();
    check_reset("por");
    rst = 1;
    tick();

    push(32'h1000, 32'h2000, 8'd15);
    push(32'h1040, 32'h2040, 8'd15);
    push(32'h1080, 32'h2080, 8'd7);
    run_job(32'h1000, 32'h2000, 40, 0, -1, 0);

    push(32'h0FF8, 32'h3000, 8'd1);
    push(32'h1000, 32'h3008, 8'd7);
    run_job(32'h0FF8, 32'h3000, 10, 0, -1, 0);

    run_job(32'h4000, 32'h5000, 0, 0, -1, 0);

    push(32'h0000, 32'h0100, 8'd15);
    push(32'h0040, 32'h0140, 8'd3);
    run_job(32'h0000, 32'h0100, 20, 5, -1, 0);

    push(32'h5000, 32'h6000, 8'd15);
    push_rd(32'h5040, 8'd15);
    run_job(32'h5000, 32'h6000, 32, 0, 1, 0);

    push(32'h7000, 32'h8FFC, 8'd0);
    push(32'h7004, 32'h9000, 8'd1);
    run_job(32'h7003, 32'h8FFC, 3, 0, -1, 0);

    push(32'hA000, 32'hB000, 8'd3);
    run_job(32'hA000, 32'hB000, 4, 0, -1, 1);

    push(32'hFFFF_FFF8, 32'h0010, 8'd1);
    push(32'h0000_0000, 32'h0018, 8'd1);
    run_job(32'hFFFF_FFF8, 32'h0010, 4, 0, -1, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
